// File: rtl/uart_opb_frame_parser.sv
// UART-to-OPB command frame parser: 10-byte frames in, one OPB access per frame, 10-byte echo response out.
// Optional ERR_CNT port/counter is built only when PARSER_ERR_CNT_EN is defined.
module uart_opb_frame_parser #(
  parameter int          BYTE_TIMEOUT = 100000,
  parameter int          ACK_TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        SYS_CLK,
  input  logic        RESET_N,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OPB_WDATA,
  output logic        OPB_WE,
  output logic        OPB_RE,
  input  logic [31:0] OPB_RDATA,
  input  logic        OPB_ACK,
  output logic        BUSY,
  output logic        FRAME_ERR,
  output logic [2:0]  DBG_STATE
`ifdef PARSER_ERR_CNT_EN
  ,
  output logic [15:0] ERR_CNT
`endif
);

  localparam int BTW = $clog2(BYTE_TIMEOUT + 1);
  localparam int ATW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_OPB_REQ  = 3'd2,
    S_OPB_WAIT = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t         r_state;
  logic           r_is_rd;
  logic [3:0]     r_idx;
  logic [63:0]    r_shift;
  logic [BTW-1:0] r_byte_tmr;
  logic [ATW-1:0] r_ack_tmr;
  logic [79:0]    r_resp;
  logic [3:0]     r_tx_cnt;
  logic [7:0]     r_tx_data;
  logic           r_tx_valid;
  logic [31:0]    r_addr;
  logic [31:0]    r_wdata;
  logic           r_we;
  logic           r_re;
  logic           r_frame_err;
  logic [7:0]     w_hdr;
  logic [7:0]     w_trl;

  assign w_hdr     = r_is_rd ? 8'h5B : 8'h5A;
  assign w_trl     = r_is_rd ? 8'hA4 : 8'hA5;
  assign TX_DATA   = r_tx_data;
  assign TX_VALID  = r_tx_valid;
  assign OPB_ADDR  = r_addr;
  assign OPB_WDATA = r_wdata;
  assign OPB_WE    = r_we;
  assign OPB_RE    = r_re;
  assign FRAME_ERR = r_frame_err;
  assign BUSY      = (r_state != S_IDLE);
  assign DBG_STATE = r_state;

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_is_rd     <= 1'b0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_byte_tmr  <= '0;
      r_ack_tmr   <= '0;
      r_resp      <= '0;
      r_tx_cnt    <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (RX_VALID) begin
            if (RX_DATA == 8'h5A || RX_DATA == 8'h5B) begin
              r_is_rd    <= RX_DATA[0];
              r_idx      <= 4'd1;
              r_byte_tmr <= '0;
              r_state    <= S_COLLECT;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (RX_VALID) begin
            r_byte_tmr <= '0;
            if (r_idx == 4'd9) begin
              if (RX_DATA == w_trl) begin
                r_addr    <= r_shift[63:32];
                r_wdata   <= r_shift[31:0];
                r_we      <= !r_is_rd;
                r_re      <= r_is_rd;
                r_ack_tmr <= '0;
                r_state   <= S_OPB_REQ;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
              end
            end else begin
              r_shift <= {r_shift[55:0], RX_DATA};
              r_idx   <= r_idx + 4'd1;
            end
          end else if (r_byte_tmr == BTW'(BYTE_TIMEOUT - 1)) begin
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_byte_tmr <= r_byte_tmr + 1'b1;
          end
        end
        S_OPB_REQ, S_OPB_WAIT: begin
          if (RX_VALID) r_frame_err <= 1'b1;
          // The request is already on the bus in OPB_REQ, so an ack there counts.
          if (OPB_ACK) begin
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_resp   <= {w_hdr, r_addr, (r_re ? OPB_RDATA : r_wdata), w_trl};
            r_tx_cnt <= '0;
            r_state  <= S_RESP;
          end else if (r_ack_tmr == ATW'(ACK_TIMEOUT - 1)) begin
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_resp      <= {w_hdr, r_addr, ERR_DATA, w_trl};
            r_tx_cnt    <= '0;
            r_frame_err <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_ack_tmr <= r_ack_tmr + 1'b1;
            r_state   <= S_OPB_WAIT;
          end
        end
        S_RESP: begin
          if (RX_VALID) r_frame_err <= 1'b1;
          if (!r_tx_valid) begin
            r_tx_data  <= r_resp[79:72];
            r_resp     <= {r_resp[71:0], 8'h00};
            r_tx_valid <= 1'b1;
            r_tx_cnt   <= 4'd1;
          end else if (TX_READY) begin
            if (r_tx_cnt == 4'd10) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_tx_data <= r_resp[79:72];
              r_resp    <= {r_resp[71:0], 8'h00};
              r_tx_cnt  <= r_tx_cnt + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PARSER_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  assign ERR_CNT = r_err_cnt;

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_err_cnt <= '0;
    end else if (r_frame_err && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_opb_frame_parser.sv
// Directed bench for uart_opb_frame_parser: expected TX bytes and OPB requests are queued
// by the stimulus and consumed by independent monitors.
module tb_uart_opb_frame_parser;

  localparam int BT = 200;
  localparam int AT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] opb_addr;
  logic [31:0] opb_wdata;
  logic        opb_we;
  logic        opb_re;
  logic [31:0] opb_rdata;
  logic        opb_ack;
  logic        busy;
  logic        frame_err;
  logic [2:0]  dbg_state;
`ifdef PARSER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  uart_opb_frame_parser #(.BYTE_TIMEOUT(BT), .ACK_TIMEOUT(AT)) dut (
    .SYS_CLK(clk), .RESET_N(rst_n),
    .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .OPB_ADDR(opb_addr), .OPB_WDATA(opb_wdata), .OPB_WE(opb_we), .OPB_RE(opb_re),
    .OPB_RDATA(opb_rdata), .OPB_ACK(opb_ack),
    .BUSY(busy), .FRAME_ERR(frame_err), .DBG_STATE(dbg_state)
`ifdef PARSER_ERR_CNT_EN
    , .ERR_CNT(err_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_q[$];
  logic [65:0] opb_q[$];
  int          len_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ferr_seen = 0;
  int          ack_delay = 0;
  bit          no_ack = 1'b0;
  logic [31:0] rd_val = '0;
  int          ready_mode = 0;

  function automatic void chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- TX monitor ----------------
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got byte %0h expected none", tx_data);
        end else begin
          chk("tx_byte", tx_data, exp_q.pop_front());
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  // ---------------- OPB monitor ----------------
  bit req_prev = 1'b0;
  int req_len  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
      req_len  = 0;
    end else begin
      if (frame_err) ferr_seen++;
      if ((opb_we || opb_re) && !req_prev) begin
        chk("opb_onehot", opb_we & opb_re, 0);
        if (opb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL opb_unexpected: got we=%0b re=%0b expected none", opb_we, opb_re);
        end else begin
          chk("opb_req", {opb_we, opb_re, opb_addr, opb_wdata}, opb_q.pop_front());
        end
        req_len = 0;
      end
      if (opb_we || opb_re) req_len++;
      if (!(opb_we || opb_re) && req_prev && len_q.size() != 0)
        chk("opb_len", req_len, len_q.pop_front());
      req_prev = opb_we || opb_re;
    end
  end

  // ---------------- OPB slave and TX_READY drivers ----------------
  int slv_cnt = 0;
  initial begin
    opb_ack   = 1'b0;
    opb_rdata = '0;
    forever begin
      @(posedge clk); #1;
      opb_ack = 1'b0;
      if (opb_we || opb_re) begin
        if (!no_ack && slv_cnt == ack_delay) begin
          opb_ack   = 1'b1;
          opb_rdata = rd_val;
        end
        slv_cnt++;
      end else begin
        slv_cnt = 0;
      end
    end
  end

  int ph = 0;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) begin
        tx_ready = 1'b1;
      end else begin
        tx_ready = (ph == 0);
        ph = (ph + 1) % 4;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [79:0] f);
    for (int i = 0; i < 10; i++) send_byte(f[79 - 8*i -: 8]);
  endtask

  task automatic expect_resp(input logic [79:0] r);
    for (int i = 0; i < 10; i++) exp_q.push_back(r[79 - 8*i -: 8]);
  endtask

  task automatic expect_opb(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] d, input int len);
    opb_q.push_back({we, re, a, d});
    len_q.push_back(len);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || opb_q.size() != 0 || len_q.size() != 0 || busy) && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, (n < budget), 1);
  endtask

  task automatic check_reset(input string name);
    chk(name, {tx_valid, tx_data, opb_addr, opb_wdata, opb_we, opb_re, busy, frame_err, dbg_state}, 0);
  endtask

  // ---------------- stimulus ----------------
  int f0;
  int n;
  initial begin
    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    #22;
    check_reset("reset_state");
`ifdef PARSER_ERR_CNT_EN
    chk("err_cnt_reset", err_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(3);

    // stray byte in IDLE
    f0 = ferr_seen;
    send_byte(8'h00);
    cyc(3);
    chk("idle_drop_ferr", ferr_seen - f0, 1);

    // write, ack two cycles after OPB_WE
    f0 = ferr_seen;
    ack_delay = 2;
    expect_opb(1'b1, 1'b0, 32'h0004_0008, 32'h0000_1234, 3);
    expect_resp(80'h5A_00_04_00_08_00_00_12_34_A5);
    send_frame(80'h5A_00_04_00_08_00_00_12_34_A5);
    wait_done("write_done", 500);
    chk("write_ferr", ferr_seen - f0, 0);

    // read, ack in the same cycle the request rises
    ack_delay = 0;
    rd_val = 32'h1122_3344;
    expect_opb(1'b0, 1'b1, 32'h0001_0000, 32'h0000_0000, 1);
    expect_resp(80'h5B_00_01_00_00_11_22_33_44_A4);
    send_frame(80'h5B_00_01_00_00_00_00_00_00_A4);
    wait_done("read_done", 500);

    // write header with read trailer: rejected silently
    f0 = ferr_seen;
    send_frame(80'h5A_00_00_00_10_00_00_00_01_A4);
    cyc(20);
    chk("bad_trailer_ferr", ferr_seen - f0, 1);
    chk("bad_trailer_idle", busy, 0);

    // partial frame stalls past the byte timeout, then a good read
    f0 = ferr_seen;
    send_byte(8'h5A);
    send_byte(8'h00);
    send_byte(8'h04);
    cyc(BT + 10);
    chk("byte_timeout_ferr", ferr_seen - f0, 1);
    chk("byte_timeout_idle", busy, 0);
    ack_delay = 1;
    rd_val = 32'hA5A5_5A5A;
    expect_opb(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 2);
    expect_resp(80'h5B_00_00_00_20_A5_A5_5A_5A_A4);
    send_frame(80'h5B_00_00_00_20_00_00_00_00_A4);
    wait_done("read_after_timeout", 500);

    // read never acked; a byte arriving mid-wait is dropped
    f0 = ferr_seen;
    no_ack = 1'b1;
    expect_opb(1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, AT);
    expect_resp(80'h5B_12_34_56_78_DE_AD_BE_EF_A4);
    send_frame(80'h5B_12_34_56_78_00_00_00_00_A4);
    n = 0;
    while (!opb_re && n < 20) begin cyc(1); n++; end
    chk("ack_to_req_seen", (n < 20), 1);
    cyc(3);
    send_byte(8'h77);
    wait_done("ack_timeout_done", 500);
    chk("ack_timeout_ferr", ferr_seen - f0, 2);
    no_ack = 1'b0;
`ifdef PARSER_ERR_CNT_EN
    chk("err_cnt_total", err_cnt, 5);
`endif

    // slow transmitter, then reset in the middle of the response
    ready_mode = 1;
    ack_delay = 1;
    expect_opb(1'b1, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 2);
    expect_resp(80'h5A_00_00_00_40_CA_FE_F0_0D_A5);
    send_frame(80'h5A_00_00_00_40_CA_FE_F0_0D_A5);
    n = 0;
    while (exp_q.size() > 6 && n < 500) begin cyc(1); n++; end
    chk("mid_resp_reached", (n < 500), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check_reset("mid_resp_reset");
`ifdef PARSER_ERR_CNT_EN
    chk("err_cnt_cleared", err_cnt, 0);
`endif
    exp_q.delete();
    cyc(2);
    rst_n = 1'b1;
    ready_mode = 0;
    cyc(2);

    // frame after reset parses normally
    ack_delay = 0;
    expect_opb(1'b1, 1'b0, 32'h0000_0044, 32'h0000_0055, 1);
    expect_resp(80'h5A_00_00_00_44_00_00_00_55_A5);
    send_frame(80'h5A_00_00_00_44_00_00_00_55_A5);
    wait_done("post_reset_write", 500);
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_opb_frame_parser.md
Name: uart_opb_frame_parser

Overview:
- Sits between the UART byte receiver/transmitter and the OPB register bus inside top.
- Assembles 10-byte host command frames from received bytes and issues one OPB write or read per valid frame.
- Returns a 10-byte response frame to the UART transmitter.
- Rejects malformed or stalled frames without touching the bus.

Parameters:
- BYTE_TIMEOUT, 100000, max SYS_CLK cycles between consecutive frame bytes before the partial frame is discarded (1 ms at 100 MHz).
- ACK_TIMEOUT, 1024, max cycles OPB_WE/OPB_RE is held waiting for OPB_ACK.
- ERR_DATA, 32'hDEAD_BEEF, data returned in the response when the OPB access times out.

Ports:
- SYS_CLK  in  1  system clock, 100 MHz
- RESET_N  in  1  asynchronous active-low reset
- RX_DATA  in  8  received UART byte
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid
- TX_DATA  out  8  response byte to UART transmitter
- TX_VALID  out  1  TX_DATA valid; held until accepted
- TX_READY  in  1  transmitter can accept a byte
- OPB_ADDR  out  32  bus address
- OPB_WDATA  out  32  bus write data
- OPB_WE  out  1  write request, held until ack/timeout
- OPB_RE  out  1  read request, held until ack/timeout
- OPB_RDATA  in  32  bus read data, valid with OPB_ACK
- OPB_ACK  in  1  one-cycle bus acknowledge
- BUSY  out  1  high in any state except IDLE
- FRAME_ERR  out  1  one-cycle pulse per rejected frame or dropped byte
- ERR_CNT  out  16  error counter (only with PARSER_ERR_CNT_EN)

Behaviour:
- Reset: all outputs 0 (TX_DATA, OPB_ADDR, OPB_WDATA = 0; ERR_CNT = 0); state IDLE; byte index 0; timers cleared.
- Frame format, big-endian: byte0 header, bytes1-4 ADDR[31:0], bytes5-8 DATA[31:0], byte9 trailer. Write is 0x5A…0xA5; read is 0x5B…0xA4.
- IDLE:
  - RX_VALID with 0x5A or 0x5B: latch type, go to COLLECT, index = 1.
  - Any other byte: drop, pulse FRAME_ERR, stay in IDLE.
- COLLECT:
  - Each RX_VALID shifts the byte into the addr/data shift register; index increments.
  - At index 9, compare the trailer against the latched type.
  - Trailer match: load OPB_ADDR/OPB_WDATA, go to OPB_REQ.
  - Trailer mismatch: pulse FRAME_ERR, return to IDLE, no bus access, no response.
  - Inter-byte timer resets on every RX_VALID. On reaching BYTE_TIMEOUT: pulse FRAME_ERR, go to IDLE, discard the partial frame.
- OPB_REQ: assert OPB_WE (write) or OPB_RE (read) in the cycle after the trailer is accepted. Exactly one of them is high, never both. Go to OPB_WAIT.
- OPB_WAIT:
  - On OPB_ACK, deassert the request in the next cycle.
  - Read: capture OPB_RDATA into the response data. Write: response data = written DATA.
  - If OPB_ACK is seen in the same cycle the request asserts, it is accepted.
  - ACK_TIMEOUT reached: deassert the request, response data = ERR_DATA, pulse FRAME_ERR.
  - Go to RESP.
- RESP: send 10 bytes: header, ADDR[31:24]…ADDR[7:0], response data MSB first, trailer (echo of the command's header/trailer).
  - TX_VALID high with stable TX_DATA until the cycle TX_READY=1.
  - The next byte is presented in the following cycle; there is no combinational path TX_READY→TX_VALID.
  - After the 10th byte is accepted, go to IDLE.
- RX_VALID in OPB_REQ/OPB_WAIT/RESP: byte dropped, FRAME_ERR pulsed, state unchanged.
- Simultaneous RX_VALID and timeout expiry in COLLECT: the byte is accepted and the timer reloads.
- Reset mid-operation: OPB_WE/OPB_RE and TX_VALID drop immediately (async). The partial frame and response are discarded.
- Latency from trailer RX_VALID to first TX_VALID: 3 cycles + OPB ack latency.

Optional Feature:
- Macro: PARSER_ERR_CNT_EN
- Defined: ERR_CNT increments on every FRAME_ERR pulse and saturates at 16'hFFFF. Cleared only by reset.
- Undefined: ERR_CNT port and counter are absent; FRAME_ERR is still generated.

Test Plan:
- Write 5A 00 04 00 08 00 00 12 34 A5, OPB_ACK 2 cycles after OPB_WE → OPB_ADDR=0x00040008, OPB_WDATA=0x00001234, single OPB_WE burst; response 5A 00 04 00 08 00 00 12 34 A5.
- Read 5B 00 01 00 00 00 00 00 00 A4, OPB_RDATA=0x11223344 with ACK → OPB_RE only; response 5B 00 01 00 00 11 22 33 44 A4.
- Write frame with trailer A4 → FRAME_ERR pulse, no OPB_WE, no TX_VALID; ERR_CNT=1 with macro.
- Send 5A 00 04 then idle > BYTE_TIMEOUT, then a valid read frame → FRAME_ERR once; the read completes normally.
- Read with OPB_ACK never asserted → OPB_RE deasserts after ACK_TIMEOUT cycles; response data DE AD BE EF; FRAME_ERR pulsed.
- TX_READY toggled 1 cycle on / 3 off during response; RESET_N pulsed low mid-response → every byte held stable until accepted; after reset all outputs are 0 and the next frame parses correctly.
